latch_scan: RTL and testbench

LATCH_SCAN -- requirements
Module: latch_scan

---
 rtl/latch_scan_pkg.sv | 15 +
 rtl/latch_scan_rr_pick.sv | 28 ++
 rtl/latch_scan.sv | 111 +++++++++++
 tb/tb_latch_scan.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/latch_scan_pkg.sv
// rtl/latch_scan_pkg.sv - shared FSM state type and default sizing for latch_scan
package latch_scan_pkg;

  // Default number of scanned status bits and offer timeout length
  localparam int W_DEF   = 4;
  localparam int TMO_DEF = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    CLEAR  = 2'd2,
    SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/latch_scan_rr_pick.sv
// rtl/latch_scan_rr_pick.sv - round-robin first-set-bit search starting after ptr
module rr_pick #(
  parameter int W  = 4,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  // Walk from the farthest candidate back to ptr+1 so the nearest set bit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = W; k >= 1; k--) begin
      pos = IW'((int'(ptr) + k) % W);
      if (vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/latch_scan.sv
// rtl/latch_scan.sv - scans latched status bits, offers one at a time, clears on ack
module latch_scan
  import latch_scan_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [W-1:0]         i_latched,
  input  logic                 i_ack,
  output logic                 o_req,
  output logic [$clog2(W)-1:0] o_id,
  output logic [W-1:0]         o_clear,
  output logic                 o_tmo
);

  localparam int IW = $clog2(W);

  state_t        state, state_nxt;
  logic [IW-1:0] id_q, id_nxt;
  logic [IW-1:0] ptr_q, ptr_nxt;
  logic [7:0]    cnt_q, cnt_nxt;
  logic          tmo_q, tmo_nxt;
  logic          live_q;
  logic          found;
  logic [IW-1:0] pick;

  rr_pick #(.W(W), .IW(IW)) u_pick (
    .vec   (i_latched),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick)
  );

  // Hold off scanning for one edge after reset release so no offer appears on the first edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) live_q <= 1'b0;
    else          live_q <= 1'b1;
  end

  // State register; ptr resets to W-1 so bit 0 is searched first
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      id_q  <= '0;
      ptr_q <= IW'(W - 1);
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_nxt;
      id_q  <= id_nxt;
      ptr_q <= ptr_nxt;
      cnt_q <= cnt_nxt;
      tmo_q <= tmo_nxt;
    end
  end

  // Next-state logic: withdraw beats ack, ack beats timeout
  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (live_q && found) begin
          id_nxt    = pick;
          cnt_nxt   = 8'd1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (!i_latched[id_q]) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (i_ack) begin
          cnt_nxt   = '0;
          state_nxt = CLEAR;
        end else if (cnt_q == 8'(TMO)) begin
          tmo_nxt   = 1'b1;
          ptr_nxt   = id_q;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      CLEAR: begin
        ptr_nxt   = id_q;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state, so reset forces them low immediately
  always_comb begin
    o_req   = (state == OFFER);
    o_id    = id_q;
    o_clear = (state == CLEAR) ? (W'(1) << id_q) : '0;
    o_tmo   = tmo_q;
  end

endmodule

// File: tb/tb_latch_scan.sv
// tb/tb_latch_scan.sv - directed self-checking bench for latch_scan
module tb_latch_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] latched;
  logic       ack;
  logic       req;
  logic [1:0] id;
  logic [3:0] clear;
  logic       tmo;

  int vectors;
  int miscompares;

  latch_scan #(.W(4), .TMO(15)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_latched (latched),
    .i_ack     (ack),
    .o_req     (req),
    .o_id      (id),
    .o_clear   (clear),
    .o_tmo     (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    latched = 4'b0000;
    ack     = 1'b0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_id", id, 0);
    chk("rst_clear", clear, 0);
    chk("rst_tmo", tmo, 0);
    step();
    step();
    rst_n   = 1'b1;
    latched = 4'b1000;
    ack     = 1'b1;

    // single bit 3, ack held
    step();
    chk("t1_no_offer_first_edge", req, 0);
    step();
    chk("t1_req", req, 1);
    chk("t1_id", id, 3);
    chk("t1_clear_off", clear, 0);
    step();
    chk("t1_req_drop", req, 0);
    chk("t1_clear", clear, 4'b1000);
    latched = 4'b0000;
    step();
    chk("t1_settle_clear", clear, 0);
    chk("t1_settle_req", req, 0);
    step();
    step();
    chk("t1_idle_req", req, 0);

    // service bit 0 so ptr becomes 0
    latched = 4'b0001;
    step();
    chk("t2pre_id", id, 0);
    step();
    chk("t2pre_clear", clear, 4'b0001);
    latched = 4'b0000;
    step();
    step();

    // 0101 with ptr=0: bit 2 then bit 0
    latched = 4'b0101;
    step();
    chk("t2_req_a", req, 1);
    chk("t2_id_a", id, 2);
    step();
    chk("t2_clear_a", clear, 4'b0100);
    latched = 4'b0001;
    step();
    step();
    step();
    chk("t2_req_b", req, 1);
    chk("t2_id_b", id, 0);
    step();
    chk("t2_clear_b", clear, 4'b0001);
    latched = 4'b0000;
    step();
    step();

    // timeout on bit 1, ptr=0, ack low
    latched = 4'b0010;
    ack     = 1'b0;
    step();
    chk("t3_req", req, 1);
    chk("t3_id", id, 1);
    for (int i = 0; i < 14; i++) begin
      step();
      chk("t3_hold_tmo", tmo, 0);
      chk("t3_hold_req", req, 1);
    end
    step();
    chk("t3_tmo_pulse", tmo, 1);
    chk("t3_tmo_req", req, 0);
    chk("t3_tmo_clear", clear, 0);
    latched = 4'b0011;
    step();
    chk("t3_tmo_once", tmo, 0);
    chk("t3_ptr_is_1", id, 0);
    chk("t3_reoffer_req", req, 1);

    // withdraw bit 0 with ack high: no clear, ptr stays 1
    latched = 4'b0110;
    ack     = 1'b1;
    step();
    chk("t4_withdraw_req", req, 0);
    chk("t4_withdraw_clear", clear, 0);
    step();
    chk("t4_ptr_kept", id, 2);
    chk("t4_req", req, 1);

    // reset during CLEAR
    step();
    chk("t5_clear", clear, 4'b0100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_clear", clear, 0);
    chk("t5_async_req", req, 0);
    ack = 1'b0;
    step();
    chk("t5_in_reset_clear", clear, 0);
    rst_n = 1'b1;
    step();
    chk("t5_no_offer_first_edge", req, 0);
    step();
    chk("t5_req", req, 1);
    chk("t5_lowest_id", id, 1);
    chk("t5_clear_off", clear, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
